imem_fetch_ctrl: RTL
====================

// Module: imem_fetch_ctrl
// PURPOSE
//  Instruction-memory front end directly upstream of if_stage. Takes the PC (if_stage rom_addr) and issues single-beat
//  reads over a valid/ready request + valid response bus (latency >= 1 cycle). Delivers instr to if_stage instr_if_i.
//  Holds PC via fetch_stall until a word is consumed. Squashes in-flight words on PL_flush; buffers one word across PL_stall.
// PARAMETERS
//  ADDR_W   32            fetch/request address width
//  DATA_W   32            instruction word width
//  NOP_INSTR 32'h00000013 word driven on instr_out when instr_valid=0 (addi x0,x0,0 = `nop)
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  rst            in   1       reset, synchronous, active-high
//  fetch_addr     in   ADDR_W  current PC from if_stage (rom_addr)
//  PL_stall       in   1       downstream cannot consume this cycle (PL_stall | PL_stall_inner)
//  PL_flush       in   1       redirect: PC reloads pc_rollback next edge; any pending/held word is wrong-path
//  mem_req_valid  out  1       read request valid
//  mem_req_addr   out  ADDR_W  request address, bits[1:0] forced 0
//  mem_req_ready  in   1       memory accepts request this cycle
//  mem_resp_valid in   1       read data valid (in order, exactly one per accepted request)
//  mem_resp_data  in   DATA_W  read data
//  instr_out      out  DATA_W  instruction to if_stage; NOP_INSTR when !instr_valid
//  instr_valid    out  1       instr_out is a real, correct-path word
//  instr_pc       out  ADDR_W  address instr_out was fetched from (debug/trace)
//  fetch_stall    out  1       hold PC; OR into pc_reg stall
// BEHAVIOUR
//  - States: IDLE, REQ, WAIT, HOLD. Reset -> IDLE; all regs 0, drop=0, mem_req_valid=0, instr_valid=0,
//    instr_out=NOP_INSTR, fetch_stall=1. rst mid-transaction abandons it; responses are ignored until first REQ issue.
//  - IDLE: exactly one cycle, -> REQ.
//  - REQ: mem_req_valid=1, mem_req_addr={fetch_addr[ADDR_W-1:2],2'b00}. On mem_req_ready: latch req_pc, -> WAIT;
//    drop <= PL_flush (request issued in a flush cycle carries the stale PC). No ready: stay, addr tracks fetch_addr.
//  - WAIT: mem_req_valid=0. PL_flush without resp sets drop=1.
//    resp & (drop|PL_flush): discard, drop<=0, -> REQ.
//    resp & !PL_stall: combinational pass-through: instr_valid=1, instr_out=mem_resp_data, instr_pc=req_pc; -> REQ.
//    resp & PL_stall: hold_buf<=mem_resp_data, -> HOLD (instr_valid=0 this cycle).
//  - HOLD: instr_valid=1, instr_out=hold_buf. !PL_stall: consumed, -> REQ. PL_flush: discard buf, -> REQ
//    (flush wins over consume; instr_valid forced 0 in flush cycle).
//  - fetch_stall = !(instr_valid & !PL_stall) & !PL_flush. Flush always releases PC so the redirect loads.
//  - Latency: min 2 cycles addr->instr (REQ issue + 1-cycle memory); steady state 1 word per 2 cycles, 1 outstanding.
//  - mem_resp_valid outside WAIT (and not post-reset stray) is ignored; assertion flags it in sim.
//  - PL_stall and PL_flush both high: flush semantics apply.
//  - instr_valid never high for a word whose request or response coincided with/followed a flush before delivery.
// STRUCTURE
//  - Shared define.v: `nop, state encodings FETCH_IDLE/REQ/WAIT/HOLD (2-bit localparams).
//  - One sub-module: fetch_hold_buf (1-entry DATA_W+ADDR_W register, load/clear/valid); FSM + drop flag in top.
//  - Output muxes combinational from state + inputs; no other registered outputs.
// TESTING
//  - Reset, mem latency 1, ready=1, addr 0x0 data 0x00500093: instr_valid at cycle 3, instr_pc=0, fetch_stall=0 that cycle.
//  - Resp 0x00A00113 with PL_stall=1 for 3 cycles: HOLD, instr_out=0x00A00113 valid all 3, fetch_stall=1; released cycle 4.
//  - PL_flush during WAIT at 0x40, resp 0xDEADBEEF 2 cycles later: discarded, instr_valid=0, next req_addr=new PC 0x100.
//  - PL_flush same cycle as resp and same cycle as request accept: both words dropped, no instr_valid pulse.
//  - mem_req_ready low 5 cycles, fetch_addr=0x3 -> req held, mem_req_addr=0x0, fetch_stall=1 throughout.
//  - rst asserted in WAIT, resp arrives next cycle: ignored; after release first valid word is from post-reset fetch_addr.

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-memory fetch front end:
// FSM state encoding and the default bubble instruction.
package imem_fetch_ctrl_pkg;

  // Fetch controller states (2-bit encoding).
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_HOLD = 2'd3
  } fetch_state_e;

  // addi x0,x0,0 -- the canonical RISC-V nop, fed to if_stage as a bubble.
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/imem_fetch_ctrl_hold_buf.sv
// Single-entry holding register for a fetched word and its address.
// Captures a response that arrived while the pipeline was stalled and
// keeps it until it is consumed or squashed.
module imem_fetch_ctrl_hold_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] load_pc,
  output logic [DATA_W-1:0] buf_data,
  output logic [ADDR_W-1:0] buf_pc,
  output logic              buf_valid
);

  logic [DATA_W-1:0] data_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic              valid_reg;

  // Load takes a new word; clear drops it. The controller never asserts both.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg  <= '0;
      pc_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      data_reg  <= load_data;
      pc_reg    <= load_pc;
      valid_reg <= 1'b1;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end
  end

  assign buf_data  = data_reg;
  assign buf_pc    = pc_reg;
  assign buf_valid = valid_reg;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory front end sitting in front of if_stage. Issues one
// single-beat read at a time for the current PC, passes the returned word
// straight through when the pipeline can take it, parks it in a one-entry
// buffer across a stall, and squashes wrong-path words around a flush.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              PL_stall,
  input  logic              PL_flush,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fetch_stall
);

  fetch_state_e      state_reg, state_next;
  logic              drop_reg, drop_next;
  logic [ADDR_W-1:0] req_pc_reg, req_pc_next;
  // Set by reset, cleared once the first request is issued; only used to
  // excuse a late response from a request abandoned by reset.
  logic              post_rst_reg, post_rst_next;

  logic              hold_load, hold_clear;
  logic [DATA_W-1:0] hold_data;
  logic [ADDR_W-1:0] hold_pc;
  logic              hold_valid;

  // Fetches are word aligned; the low PC bits never reach the bus.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^fetch_addr[1:0];
  assign mem_req_addr    = {fetch_addr[ADDR_W-1:2], 2'b00};

  imem_fetch_ctrl_hold_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_load),
    .clear     (hold_clear),
    .load_data (mem_resp_data),
    .load_pc   (req_pc_reg),
    .buf_data  (hold_data),
    .buf_pc    (hold_pc),
    .buf_valid (hold_valid)
  );

  // State, wrong-path flag and issued-address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= FETCH_IDLE;
      drop_reg     <= 1'b0;
      req_pc_reg   <= '0;
      post_rst_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      drop_reg     <= drop_next;
      req_pc_reg   <= req_pc_next;
      post_rst_reg <= post_rst_next;
    end
  end

  // Next-state logic and all combinational outputs.
  always_comb begin
    state_next    = state_reg;
    drop_next     = drop_reg;
    req_pc_next   = req_pc_reg;
    post_rst_next = post_rst_reg;
    hold_load     = 1'b0;
    hold_clear    = 1'b0;
    mem_req_valid = 1'b0;
    instr_valid   = 1'b0;
    instr_out     = NOP_INSTR;
    instr_pc      = req_pc_reg;

    case (state_reg)
      FETCH_IDLE: begin
        state_next = FETCH_REQ;
      end
      FETCH_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          // A request accepted during a flush was built from the stale PC.
          req_pc_next   = mem_req_addr;
          drop_next     = PL_flush;
          post_rst_next = 1'b0;
          state_next    = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (mem_resp_valid) begin
          if (drop_reg || PL_flush) begin
            drop_next  = 1'b0;
            state_next = FETCH_REQ;
          end else if (!PL_stall) begin
            instr_valid = 1'b1;
            instr_out   = mem_resp_data;
            state_next  = FETCH_REQ;
          end else begin
            hold_load  = 1'b1;
            state_next = FETCH_HOLD;
          end
        end else if (PL_flush) begin
          drop_next = 1'b1;
        end
      end
      FETCH_HOLD: begin
        // Flush beats consume: the held word is wrong-path and never shown.
        instr_valid = hold_valid && !PL_flush;
        instr_out   = instr_valid ? hold_data : NOP_INSTR;
        instr_pc    = hold_pc;
        if (PL_flush || !PL_stall) begin
          hold_clear = 1'b1;
          state_next = FETCH_REQ;
        end
      end
      default: begin
        state_next = FETCH_IDLE;
      end
    endcase

    // A flush always releases the PC so the redirect target can load.
    fetch_stall = !(instr_valid && !PL_stall) && !PL_flush;
  end

  // Responses are only legal while a request is outstanding, apart from a
  // late reply to a request abandoned by reset.
  always_ff @(posedge clk) begin
    if (!rst && mem_resp_valid && !post_rst_reg) begin
      assert (state_reg == FETCH_WAIT);
    end
  end

endmodule
